// File: rtl/sd_bd_dispatch_pkg.sv
// Shared types and constants for the SD buffer-descriptor dispatcher.
// Holds the FSM encoding, slot count and descriptor word indices.
package sd_bd_dispatch_pkg;

    localparam int BD_SLOTS = 8;

    localparam int SRC = 0;
    localparam int BLK = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        W_SRC,
        RD_BLK,
        W_BLK,
        START,
        W_XFER,
        CMPL
    } state_e;

endpackage

// File: rtl/sd_bd_watchdog.sv
// Saturating transfer watchdog; expired_o flags the cycle whose
// increment brings the elapsed count up to the limit (0 = disabled).
module sd_bd_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [TMO_W-1:0] limit_i,
    output logic             expired_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic [TMO_W-1:0] nxt;
    logic [TMO_W:0]   inc;

    assign inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
    assign nxt = inc[TMO_W] ? cnt_q : inc[TMO_W-1:0];

    assign expired_o = en_i && (limit_i != '0) && (nxt >= limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_bd_dispatch.sv
// Pops two-word descriptors from the BD store, launches one SD block
// transfer per descriptor and returns the slot with an a_cmp pulse.
module sd_bd_dispatch #(
    parameter int RAM_MEM_WIDTH = 32,
    parameter int BD_WIDTH      = 8,
    parameter int BD_SLOTS      = sd_bd_dispatch_pkg::BD_SLOTS,
    parameter int TMO_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [BD_WIDTH-1:0]      free_bd,
    output logic                     re_s,
    input  logic                     ack_o_s,
    input  logic [RAM_MEM_WIDTH-1:0] dat_out_s,
    output logic                     a_cmp,
    output logic                     xfer_start,
    output logic [RAM_MEM_WIDTH-1:0] xfer_buf_addr,
    output logic [RAM_MEM_WIDTH-1:0] xfer_blk_addr,
    input  logic                     xfer_done,
    input  logic                     xfer_err,
    input  logic [TMO_W-1:0]         tmo_limit,
    input  logic                     err_clr,
    output logic                     busy,
    output logic                     err,
    output logic [15:0]              done_cnt
);

    import sd_bd_dispatch_pkg::*;

    state_e                   state_q, state_d;
    logic [RAM_MEM_WIDTH-1:0] addr_q [2];
    logic                     err_q;
    logic [15:0]              done_cnt_q;
    logic                     pending;
    logic                     set_err;
    logic                     cmpl_ok;
    logic                     wd_clr;
    logic                     wd_en;
    logic                     wd_exp;

    assign pending = free_bd < BD_WIDTH'(BD_SLOTS);

    sd_bd_watchdog #(
        .TMO_W (TMO_W)
    ) u_wd (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .limit_i   (tmo_limit),
        .expired_o (wd_exp)
    );

    always_comb begin
        state_d    = state_q;
        re_s       = 1'b0;
        xfer_start = 1'b0;
        a_cmp      = 1'b0;
        set_err    = 1'b0;
        cmpl_ok    = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && pending && !err_q) state_d = RD_SRC;
            end
            RD_SRC: begin
                re_s    = 1'b1;
                state_d = W_SRC;
            end
            W_SRC: begin
                if (ack_o_s) state_d = RD_BLK;
            end
            RD_BLK: begin
                re_s    = 1'b1;
                state_d = W_BLK;
            end
            W_BLK: begin
                if (ack_o_s) state_d = START;
            end
            START: begin
                xfer_start = 1'b1;
                wd_clr     = 1'b1;
                state_d    = W_XFER;
            end
            W_XFER: begin
                wd_en = 1'b1;
                // error beats done; done beats a same-cycle timeout
                if (xfer_err) begin
                    set_err = 1'b1;
                    state_d = CMPL;
                end else if (xfer_done) begin
                    cmpl_ok = 1'b1;
                    state_d = CMPL;
                end else if (wd_exp) begin
                    set_err = 1'b1;
                    state_d = CMPL;
                end
            end
            CMPL: begin
                a_cmp   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q[SRC] <= '0;
            addr_q[BLK] <= '0;
            err_q       <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == W_SRC && ack_o_s) addr_q[SRC] <= dat_out_s;
            if (state_q == W_BLK && ack_o_s) addr_q[BLK] <= dat_out_s;
            if (set_err) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (cmpl_ok) done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign xfer_buf_addr = addr_q[SRC];
    assign xfer_blk_addr = addr_q[BLK];
    assign busy          = state_q != IDLE;
    assign err           = err_q;
    assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_sd_bd_dispatch.sv
// Directed bench for sd_bd_dispatch with a BD-store model and a
// descriptor scoreboard checked at every xfer_start.
module tb_sd_bd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  free_bd;
    logic        re_s;
    logic        ack_o_s;
    logic [31:0] dat_out_s;
    logic        a_cmp;
    logic        xfer_start;
    logic [31:0] xfer_buf_addr;
    logic [31:0] xfer_blk_addr;
    logic        xfer_done;
    logic        xfer_err;
    logic [15:0] tmo_limit;
    logic        err_clr;
    logic        busy;
    logic        err;
    logic [15:0] done_cnt;

    always #5 clk = ~clk;

    sd_bd_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .free_bd       (free_bd),
        .re_s          (re_s),
        .ack_o_s       (ack_o_s),
        .dat_out_s     (dat_out_s),
        .a_cmp         (a_cmp),
        .xfer_start    (xfer_start),
        .xfer_buf_addr (xfer_buf_addr),
        .xfer_blk_addr (xfer_blk_addr),
        .xfer_done     (xfer_done),
        .xfer_err      (xfer_err),
        .tmo_limit     (tmo_limit),
        .err_clr       (err_clr),
        .busy          (busy),
        .err           (err),
        .done_cnt      (done_cnt)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] blk;
    } desc_t;

    desc_t       sb[$];
    logic [31:0] words[$];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int re_cnt = 0;
    int acmp_cnt = 0;
    int start_cyc = 0;
    int lat = 0;
    int cd = 0;
    int mode = 0;
    int n_dly = 0;
    bit ack_nxt = 0;
    bit inj_done = 0;
    bit inflight = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 done, 1 err, 2 never, 3 done+err, n_dly cycles after start
    task automatic cyc();
        desc_t d;
        @(posedge clk);
        #1;
        cyc_n++;
        ack_o_s = ack_nxt;
        ack_nxt = 0;
        if (ack_o_s && words.size() > 0) dat_out_s = words.pop_front();
        else dat_out_s = 32'hBAD0_BAD0;
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        if (inj_done) begin
            xfer_done = 1'b1;
            inj_done  = 0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                xfer_done = (mode == 0 || mode == 3);
                xfer_err  = (mode == 1 || mode == 3);
            end
        end
        if (re_s) begin
            re_cnt++;
            ack_nxt = 1;
            chk("re_s_during_xfer", {31'd0, inflight}, 32'd0);
        end
        if (xfer_start) begin
            inflight  = 1;
            start_cyc = cyc_n;
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                d = sb.pop_front();
                chk("xfer_buf_addr", xfer_buf_addr, d.src);
                chk("xfer_blk_addr", xfer_blk_addr, d.blk);
            end
            if (mode != 2) cd = n_dly;
        end
        if (a_cmp) begin
            acmp_cnt++;
            inflight = 0;
            lat      = cyc_n - start_cyc;
            free_bd  = free_bd + 8'd1;
        end
    endtask

    task automatic add_desc(input logic [31:0] s, input logic [31:0] b);
        desc_t d;
        d.src = s;
        d.blk = b;
        words.push_back(s);
        words.push_back(b);
        sb.push_back(d);
        free_bd = free_bd - 8'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_acmp(input int n, input int bound);
        int tgt;
        int k;
        tgt = acmp_cnt + n;
        k = 0;
        while (acmp_cnt < tgt && k < bound) begin
            cyc();
            k++;
        end
        chk("acmp_wait", acmp_cnt, tgt);
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);
    endtask

    initial begin
        int r0;
        int a0;
        int k;
        rst = 1'b0;
        en = 1'b0;
        free_bd = 8'd8;
        ack_o_s = 1'b0;
        dat_out_s = '0;
        xfer_done = 1'b0;
        xfer_err = 1'b0;
        tmo_limit = '0;
        err_clr = 1'b0;
        run(3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
        chk("rst_buf", xfer_buf_addr, 32'd0);
        chk("rst_blk", xfer_blk_addr, 32'd0);
        chk("rst_strobes", {29'd0, re_s, a_cmp, xfer_start}, 32'd0);
        rst = 1'b1;
        en  = 1'b1;

        // single descriptor, done 20 cycles after start
        mode  = 0;
        n_dly = 20;
        r0 = re_cnt;
        add_desc(32'h0000_1000, 32'h0000_0040);
        wait_acmp(1, 200);
        chk("single_lat", lat, 21);
        chk("single_reads", re_cnt - r0, 2);
        chk("single_done_cnt", {16'd0, done_cnt}, 32'd1);
        chk("single_err", {31'd0, err}, 32'd0);
        cyc();
        chk("single_idle", {31'd0, busy}, 32'd0);
        chk("single_hold", xfer_buf_addr, 32'h0000_1000);

        // three queued descriptors
        n_dly = 3;
        r0 = re_cnt;
        a0 = acmp_cnt;
        add_desc(32'h0000_2000, 32'h0000_0100);
        add_desc(32'h0000_3000, 32'h0000_0200);
        add_desc(32'h0000_4000, 32'h0000_0300);
        wait_acmp(3, 500);
        run(5);
        chk("q3_reads", re_cnt - r0, 6);
        chk("q3_acmp", acmp_cnt - a0, 3);
        chk("q3_free_bd", {24'd0, free_bd}, 32'd8);
        chk("q3_done_cnt", {16'd0, done_cnt}, 32'd4);
        chk("q3_idle", {31'd0, busy}, 32'd0);

        // transfer error blocks further dispatch until err_clr
        mode  = 1;
        n_dly = 5;
        add_desc(32'h0000_5000, 32'h0000_0400);
        wait_acmp(1, 200);
        chk("xerr_err", {31'd0, err}, 32'd1);
        chk("xerr_done_cnt", {16'd0, done_cnt}, 32'd4);
        mode  = 0;
        n_dly = 3;
        add_desc(32'h0000_6000, 32'h0000_0500);
        r0 = re_cnt;
        run(20);
        chk("xerr_blocked", re_cnt - r0, 0);
        chk("xerr_idle", {31'd0, busy}, 32'd0);
        clr_err();
        wait_acmp(1, 200);
        chk("resume_reads", re_cnt - r0, 2);
        chk("resume_done_cnt", {16'd0, done_cnt}, 32'd5);

        // watchdog expiry at 10 cycles
        mode = 2;
        tmo_limit = 16'd10;
        add_desc(32'h0000_7000, 32'h0000_0600);
        wait_acmp(1, 200);
        chk("tmo_lat", lat, 11);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_done_cnt", {16'd0, done_cnt}, 32'd5);
        clr_err();

        // watchdog disabled: waits until a late done
        tmo_limit = 16'd0;
        a0 = acmp_cnt;
        add_desc(32'h0000_8000, 32'h0000_0700);
        run(100);
        chk("notmo_busy", {31'd0, busy}, 32'd1);
        chk("notmo_acmp", acmp_cnt - a0, 0);
        inj_done = 1;
        wait_acmp(1, 20);
        chk("notmo_done_cnt", {16'd0, done_cnt}, 32'd6);
        chk("notmo_err", {31'd0, err}, 32'd0);

        // done and err together: err wins
        mode  = 3;
        n_dly = 4;
        add_desc(32'h0000_9000, 32'h0000_0800);
        wait_acmp(1, 200);
        chk("both_err", {31'd0, err}, 32'd1);
        chk("both_done_cnt", {16'd0, done_cnt}, 32'd6);
        clr_err();

        // reset while waiting on the transfer
        mode = 2;
        add_desc(32'h0000_A000, 32'h0000_0900);
        k = 0;
        while (!inflight && k < 100) begin
            cyc();
            k++;
        end
        chk("rstx_reached", {31'd0, inflight}, 32'd1);
        run(3);
        rst = 1'b0;
        en  = 1'b0;
        cyc();
        chk("rstx_busy", {31'd0, busy}, 32'd0);
        chk("rstx_done_cnt", {16'd0, done_cnt}, 32'd0);
        chk("rstx_buf", xfer_buf_addr, 32'd0);
        chk("rstx_blk", xfer_blk_addr, 32'd0);
        chk("rstx_strobes", {29'd0, re_s, a_cmp, xfer_start}, 32'd0);
        rst = 1'b1;
        inflight = 0;
        r0 = re_cnt;
        run(20);
        chk("rstx_no_read", re_cnt - r0, 0);
        chk("rstx_still_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
